// File: rtl/bcdtobin_if.sv
// Start/ready/done handshake and data bundle for the bcdtobin converter.
interface bcdtobin_if #(
  parameter int BIN_W = 14
) ();
  logic             i_start;
  logic [3:0]       i_bcd3;
  logic [3:0]       i_bcd2;
  logic [3:0]       i_bcd1;
  logic [3:0]       i_bcd0;
  logic             o_ready;
  logic             o_done;
  logic             o_err;
  logic [BIN_W-1:0] o_bin;

  modport master (
    output i_start, i_bcd3, i_bcd2, i_bcd1, i_bcd0,
    input  o_ready, o_done, o_err, o_bin
  );

  modport slave (
    input  i_start, i_bcd3, i_bcd2, i_bcd1, i_bcd0,
    output o_ready, o_done, o_err, o_bin
  );
endinterface

// File: rtl/bcdtobin.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble, one shift per cycle).
// Optional digit range check enabled by defining BCDTOBIN_CHECK_EN.
module bcdtobin #(
  parameter int BIN_W = 14,
  parameter int IDX_W = 5
) (
  input  logic      i_clk,
  input  logic      i_rst,
  bcdtobin_if.slave bus
);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      bcd_q;
  logic [BIN_W-1:0] bin_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      bcd_in;
  logic             start_ok;
  logic             err_q;
  logic             bad_in;

  function automatic logic [3:0] digit_fix(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  function automatic logic [15:0] bcd_fix(input logic [15:0] b);
    return {digit_fix(b[15:12]), digit_fix(b[11:8]), digit_fix(b[7:4]), digit_fix(b[3:0])};
  endfunction

  function automatic logic bcd_bad(input logic [15:0] b);
    return (b[15:12] > 4'd9) || (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  assign bcd_in   = {bus.i_bcd3, bus.i_bcd2, bus.i_bcd1, bus.i_bcd0};
  assign start_ok = (state_q == ST_READY) && bus.i_start;

`ifdef BCDTOBIN_CHECK_EN
  assign bad_in = bcd_bad(bcd_in);
`else
  assign bad_in = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_READY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: if (bus.i_start) state_d = ST_SHIFT;
      ST_SHIFT: if (idx_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  // A rejected entry enters SHIFT with a zero index, so the done pulse lands one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bcd_q <= '0;
      bin_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      bcd_q <= bcd_in;
      bin_q <= '0;
      idx_q <= bad_in ? '0 : IDX_W'(BIN_W);
      err_q <= bad_in;
    end else if ((state_q == ST_SHIFT) && (idx_q != '0)) begin
      bin_q <= {bcd_q[0], bin_q[BIN_W-1:1]};
      bcd_q <= bcd_fix({1'b0, bcd_q[15:1]});
      idx_q <= idx_q - IDX_W'(1);
    end
  end

  assign bus.o_ready = (state_q == ST_READY);
  assign bus.o_done  = (state_q == ST_DONE);
  assign bus.o_bin   = bin_q;
  assign bus.o_err   = err_q && (state_q == ST_DONE);

endmodule

// File: tb/tb_bcdtobin.sv
// Directed scoreboard bench for bcdtobin: latency, handshake, reset and digit-check behaviour.
module tb_bcdtobin;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          lat;
    bit          chkbin;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  bcdtobin_if #(.BIN_W(14)) bus ();

  bcdtobin #(.BIN_W(14), .IDX_W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    bus.i_bcd3 = d3;
    bus.i_bcd2 = d2;
    bus.i_bcd1 = d1;
    bus.i_bcd0 = d0;
  endtask

  // mode 0: single start pulse; 1: extra start pulse with 1,1,1,1 in cycle 6;
  // 2: start held high, digits scrambled mid-conversion and restored at done.
  task automatic run_conv(input logic [3:0] d3, d2, d1, d0, input int mode, input string tag);
    exp_t e, got;
    bit   bad, seen;
    int   lat;
    bad = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
    e.bin = bad ? 14'd0 : 14'(int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0));
`ifdef BCDTOBIN_CHECK_EN
    e.err = bad;
    e.lat = bad ? 2 : 16;
    e.chkbin = 1'b1;
`else
    e.err = 1'b0;
    e.lat = 16;
    e.chkbin = !bad;
`endif
    sb.push_back(e);
    bus.i_start = 1'b1;
    set_digits(d3, d2, d1, d0);
    seen = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick();
      case (mode)
        1: begin
          bus.i_start = (c == 6);
          if (c == 6) set_digits(4'd1, 4'd1, 4'd1, 4'd1);
        end
        2: set_digits(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        default: bus.i_start = 1'b0;
      endcase
      if (bus.o_done === 1'b1) begin
        seen = 1'b1;
        lat = c;
        if (mode == 2) set_digits(d3, d2, d1, d0);
      end else begin
        chk({tag, ":ready_low"}, 32'(bus.o_ready), 32'd0);
      end
    end
    got = sb.pop_front();
    chk({tag, ":latency"}, 32'(lat), 32'(got.lat));
    chk({tag, ":err"}, 32'(bus.o_err), 32'(got.err));
    if (got.chkbin) chk({tag, ":bin"}, 32'(bus.o_bin), 32'(got.bin));
    tick();
    chk({tag, ":ready_back"}, 32'(bus.o_ready), 32'd1);
    chk({tag, ":single_done"}, 32'(bus.o_done), 32'd0);
    if (got.chkbin) chk({tag, ":bin_hold"}, 32'(bus.o_bin), 32'(got.bin));
  endtask

  initial begin
    bus.i_start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset:ready", 32'(bus.o_ready), 32'd1);
    chk("reset:done", 32'(bus.o_done), 32'd0);
    chk("reset:err", 32'(bus.o_err), 32'd0);
    chk("reset:bin", 32'(bus.o_bin), 32'd0);

    // T1
    run_conv(4'd0, 4'd0, 4'd0, 4'd0, 0, "t1_0000");

    // T2
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 0, "t2_9999");
    chk("t2_9999:const", 32'(bus.o_bin), 32'h270F);
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, 0, "t2_1234");
    chk("t2_1234:const", 32'(bus.o_bin), 32'h04D2);
    run_conv(4'd0, 4'd0, 4'd0, 4'd7, 0, "t2_0007");

    // T3
    run_conv(4'd5, 4'd0, 4'd0, 4'd0, 1, "t3_5000");
    chk("t3_5000:const", 32'(bus.o_bin), 32'h1388);

    // T4: reset mid-conversion
    bus.i_start = 1'b1;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    tick();
    bus.i_start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst:ready", 32'(bus.o_ready), 32'd1);
    chk("t4_rst:bin", 32'(bus.o_bin), 32'd0);
    chk("t4_rst:done", 32'(bus.o_done), 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t4_rst:no_done", 32'(bus.o_done), 32'd0);
    end
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, 0, "t4_0042");

    // Reset and start together: reset wins, nothing is accepted
    rst = 1'b1;
    bus.i_start = 1'b1;
    set_digits(4'd3, 4'd3, 4'd3, 4'd3);
    tick();
    rst = 1'b0;
    bus.i_start = 1'b0;
    chk("rst_start:ready", 32'(bus.o_ready), 32'd1);
    tick();
    chk("rst_start:still_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_start:bin", 32'(bus.o_bin), 32'd0);

    // T5: back-to-back with start held high
    run_conv(4'd0, 4'd1, 4'd0, 4'd0, 2, "t5_a");
    run_conv(4'd0, 4'd1, 4'd0, 4'd0, 2, "t5_b");
    run_conv(4'd0, 4'd1, 4'd0, 4'd0, 2, "t5_c");
    chk("t5:const", 32'(bus.o_bin), 32'h0064);
    bus.i_start = 1'b0;
    tick();
    tick();
    chk("t5:idle", 32'(bus.o_ready), 32'd1);

    // T6 / invalid digit handling in either build
    run_conv(4'd1, 4'hA, 4'd0, 4'd0, 0, "t6_1A00");
    run_conv(4'd0, 4'd0, 4'd1, 4'd0, 0, "t6_0010");
    chk("t6_0010:const", 32'(bus.o_bin), 32'h000A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
